// File: rtl/scroll_pkg.sv
// rtl/scroll_pkg.sv - shared types and geometry for the scroll window fetcher
package scroll_pkg;

    localparam int PIXEL_COLS  = 128;
    localparam int PIXEL_BANDS = 8;
    localparam int SKIP_W      = 10;
    localparam int COL_W       = $clog2(PIXEL_COLS);
    localparam int BAND_W      = $clog2(PIXEL_BANDS);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIXEL_COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_WAIT,
        SKIP,
        CAPTURE,
        OUT,
        DONE
    } fetch_state_t;

    // The generator walks bands back to back, so the linear column index is {band, col}.
    function automatic logic [SKIP_W-1:0] skip_count(input logic [BAND_W-1:0] band,
                                                     input logic [COL_W-1:0]  col);
        return {band, col};
    endfunction

endpackage

// File: rtl/scroll_window_fetcher_if.sv
// rtl/scroll_window_fetcher_if.sv - column byte stream towards the LED-matrix frame writer
interface scroll_window_fetcher_if;

    logic       col_valid;
    logic       col_ready;
    logic [7:0] col_data;
    logic [4:0] col_idx;
    logic       col_last;

    modport master (
        output col_valid,
        output col_data,
        output col_idx,
        output col_last,
        input  col_ready
    );

    modport slave (
        input  col_valid,
        input  col_data,
        input  col_idx,
        input  col_last,
        output col_ready
    );

endinterface

// File: rtl/gen_step_timer.sv
// rtl/gen_step_timer.sv - inverts a generator toggle and times the settle window after it
module gen_step_timer #(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_restart,
    input  logic start_next,
    output logic toggle_restart,
    output logic toggle_next,
    output logic settled
);

    localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             restart_q, restart_d;
    logic             next_q, next_d;

    always_comb begin
        cnt_d     = cnt_q;
        restart_d = restart_q;
        next_d    = next_q;
        if (start_restart) begin
            restart_d = ~restart_q;
            cnt_d     = CNT_W'(SETTLE_CYC);
        end else if (start_next) begin
            next_d = ~next_q;
            cnt_d  = CNT_W'(SETTLE_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            restart_q <= 1'b0;
            next_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
            next_q    <= next_d;
        end
    end

    // High in the last wait cycle; the caller acts on the following cycle.
    assign settled        = (cnt_q == CNT_W'(1));
    assign toggle_restart = restart_q;
    assign toggle_next    = next_q;

endmodule

// File: rtl/scroll_window_fetcher.sv
// rtl/scroll_window_fetcher.sv - steps the text pixel generator through a scrolled window of one band
module scroll_window_fetcher
    import scroll_pkg::*;
#(
    parameter int WIN_WIDTH  = 17,
    parameter int SETTLE_CYC = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           frame_start,
    input  logic [6:0]                     scroll_col,
    input  logic [2:0]                     band_sel,
    output logic                           toggle_restart,
    output logic                           toggle_next,
    input  logic [7:0]                     gen_pixels,
    scroll_window_fetcher_if.master        col,
    output logic                           busy,
    output logic                           frame_done
);

    localparam logic [COL_W-1:0] WIN_LAST = COL_W'(WIN_WIDTH - 1);

    fetch_state_t      state_q, state_d;
    logic [BAND_W-1:0] band_q, band_d;
    logic [COL_W-1:0]  cur_col_q, cur_col_d;
    logic [SKIP_W-1:0] skip_left_q, skip_left_d;
    logic [COL_W-1:0]  idx_q, idx_d;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic              last_q, last_d;

    logic start_restart, start_next, settled;

    gen_step_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_restart  (start_restart),
        .start_next     (start_next),
        .toggle_restart (toggle_restart),
        .toggle_next    (toggle_next),
        .settled        (settled)
    );

    always_comb begin
        state_d       = state_q;
        band_d        = band_q;
        cur_col_d     = cur_col_q;
        skip_left_d   = skip_left_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        valid_d       = valid_q;
        data_d        = data_q;
        last_d        = last_q;
        start_restart = 1'b0;
        start_next    = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    band_d        = band_sel;
                    cur_col_d     = scroll_col;
                    skip_left_d   = skip_count(band_sel, scroll_col);
                    idx_d         = '0;
                    last_d        = (WIN_LAST == '0);
                    busy_d        = 1'b1;
                    start_restart = 1'b1;
                    state_d       = RST_WAIT;
                end
            end
            RST_WAIT: begin
                if (settled) begin
                    state_d = (skip_left_q == '0) ? CAPTURE : SKIP;
                end
            end
            SKIP: begin
                // Issue a step whenever the previous one has fully settled.
                if (!pending_q) begin
                    start_next  = 1'b1;
                    skip_left_d = skip_left_q - 1'b1;
                end else if (settled && skip_left_q == '0) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!pending_q) begin
                    data_d  = gen_pixels;
                    valid_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (col.col_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        last_d    = ((idx_q + 1'b1) == WIN_LAST);
                        cur_col_d = cur_col_q + 1'b1;
                        if (cur_col_q == LAST_COL) begin
                            // Generator cannot step backwards: restart and re-skip to this band.
                            start_restart = 1'b1;
                            skip_left_d   = skip_count(band_q, '0);
                            state_d       = RST_WAIT;
                        end else begin
                            start_next = 1'b1;
                            state_d    = CAPTURE;
                        end
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pending_d = pending_q;
        if (start_restart || start_next) begin
            pending_d = 1'b1;
        end else if (settled) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            band_q      <= '0;
            cur_col_q   <= '0;
            skip_left_q <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            band_q      <= band_d;
            cur_col_q   <= cur_col_d;
            skip_left_q <= skip_left_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
        end
    end

    assign col.col_valid = valid_q;
    assign col.col_data  = data_q;
    assign col.col_idx   = idx_q[4:0];
    assign col.col_last  = last_q;
    assign busy          = busy_q;
    assign frame_done    = (state_q == DONE);

endmodule

// File: tb/tb_scroll_window_fetcher.sv
// tb/tb_scroll_window_fetcher.sv - randomized self-checking bench with generator and window models
module tb_scroll_window_fetcher;

    localparam int W = 17;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [6:0] scroll_col = '0;
    logic [2:0] band_sel = '0;
    logic       toggle_restart;
    logic       toggle_next;
    logic [7:0] gen_pixels = '0;
    logic       busy;
    logic       frame_done;
    bit         stall_mode = 1'b0;

    scroll_window_fetcher_if col_if();

    scroll_window_fetcher #(
        .WIN_WIDTH  (W),
        .SETTLE_CYC (S)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .scroll_col     (scroll_col),
        .band_sel       (band_sel),
        .toggle_restart (toggle_restart),
        .toggle_next    (toggle_next),
        .gen_pixels     (gen_pixels),
        .col            (col_if),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_f(input int p);
        return 8'((p * 29 + (p >> 7) * 101 + 7) & 255);
    endfunction

    // Generator: toggle edge seen one clock late, pixel data two clocks after the pointer moves.
    logic       gtr_prev = 1'b0, gtn_prev = 1'b0;
    logic [9:0] gpos = '0;
    logic [7:0] gp1 = '0;
    always @(posedge clk) begin
        gtr_prev <= toggle_restart;
        gtn_prev <= toggle_next;
        if (toggle_restart != gtr_prev)   gpos <= '0;
        else if (toggle_next != gtn_prev) gpos <= gpos + 10'd1;
        gp1        <= pix_f(int'(gpos));
        gen_pixels <= gp1;
    end

    always @(posedge clk) begin
        #1;
        col_if.col_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int   cyc = 0, last_tog = -100;
    int   n_restart = 0, n_next = 0, n_done = 0;
    int   space_viol = 0, stall_viol = 0, hold_viol = 0;
    logic prev_tr = 1'b0, prev_tn = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = '0;
    logic [4:0] prev_idx = '0;
    logic [7:0] got_data[$];
    int         got_idx[$];
    bit         got_last[$];

    always @(negedge clk) begin
        cyc++;
        if (toggle_restart !== prev_tr || toggle_next !== prev_tn) begin
            if (reset_n) begin
                if (toggle_restart !== prev_tr) n_restart++;
                if (toggle_next !== prev_tn)    n_next++;
                if (cyc - last_tog < S + 1)     space_viol++;
                if (prev_stall)                 stall_viol++;
            end
            last_tog = cyc;
        end
        if (reset_n && prev_stall &&
            (!col_if.col_valid || col_if.col_data !== prev_data ||
             col_if.col_idx !== prev_idx || col_if.col_last !== prev_last))
            hold_viol++;
        if (reset_n && col_if.col_valid && col_if.col_ready) begin
            got_data.push_back(col_if.col_data);
            got_idx.push_back(int'(col_if.col_idx));
            got_last.push_back(col_if.col_last);
        end
        if (frame_done) n_done++;
        prev_tr    = toggle_restart;
        prev_tn    = toggle_next;
        prev_stall = col_if.col_valid && !col_if.col_ready;
        prev_data  = col_if.col_data;
        prev_idx   = col_if.col_idx;
        prev_last  = col_if.col_last;
    end

    task automatic start_frame(input int band, input int scroll);
        got_data.delete();
        got_idx.delete();
        got_last.delete();
        n_restart = 0; n_next = 0; n_done = 0;
        space_viol = 0; stall_viol = 0; hold_viol = 0;
        band_sel    = 3'(band);
        scroll_col  = 7'(scroll);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected window from the scrolling rule: column k is band*128 + (scroll+k) mod 128.
    task automatic check_frame(input int band, input int scroll, input string name);
        int wrap, exp_next, gd, gi, gl, c;
        wrap     = (scroll + W - 1 > 127) ? 1 : 0;
        exp_next = band * 128 + scroll + (W - 1 - wrap) + wrap * band * 128;
        check_eq({name, "_ncols"}, got_data.size(), W);
        for (int k = 0; k < W; k++) begin
            c  = band * 128 + ((scroll + k) % 128);
            gd = (k < got_data.size()) ? int'(got_data[k]) : -1;
            gi = (k < got_idx.size())  ? got_idx[k] : -1;
            gl = (k < got_last.size()) ? int'(got_last[k]) : -1;
            check_eq($sformatf("%s_data%0d", name, k), gd, int'(pix_f(c)));
            check_eq($sformatf("%s_idx%0d", name, k), gi, k);
            check_eq($sformatf("%s_last%0d", name, k), gl, (k == W - 1) ? 1 : 0);
        end
        check_eq({name, "_restarts"}, n_restart, 1 + wrap);
        check_eq({name, "_nexts"}, n_next, exp_next);
        check_eq({name, "_spacing"}, space_viol, 0);
        check_eq({name, "_stall_toggle"}, stall_viol, 0);
        check_eq({name, "_hold"}, hold_viol, 0);
    endtask

    task automatic run_frame(input int band, input int scroll, input string name);
        bit ok;
        start_frame(band, scroll);
        check_eq({name, "_busy_on"}, busy, 1);
        wait_done(ok);
        check_eq({name, "_done_seen"}, ok, 1);
        repeat (3) @(negedge clk);
        check_eq({name, "_busy_off"}, busy, 0);
        check_eq({name, "_done_count"}, n_done, 1);
        check_frame(band, scroll, name);
    endtask

    initial begin
        bit ok;
        int b, s;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tr", toggle_restart, 0);
        check_eq("rst_tn", toggle_next, 0);
        check_eq("rst_valid", col_if.col_valid, 0);
        check_eq("rst_data", col_if.col_data, 0);
        check_eq("rst_idx", col_if.col_idx, 0);
        check_eq("rst_last", col_if.col_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", frame_done, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(0, 0, "t1");
        run_frame(3, 5, "t2");
        run_frame(2, 120, "t3");
        stall_mode = 1'b1;
        run_frame(0, 0, "t4");
        stall_mode = 1'b0;
        run_frame(0, 125, "t7");

        // Pulses while busy and during frame_done must not be taken.
        @(posedge clk);
        #1;
        start_frame(1, 3);
        repeat (10) @(posedge clk);
        #1;
        band_sel = 3'd5; scroll_col = 7'd9; frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wait_done(ok);
        check_eq("t5a_done_seen", ok, 1);
        check_frame(1, 3, "t5a");
        band_sel = 3'd6; scroll_col = 7'd44; frame_start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_done_pulse_ignored", busy, 0);
        start_frame(4, 100);
        check_eq("t5b_busy_on", busy, 1);
        wait_done(ok);
        check_eq("t5b_done_seen", ok, 1);
        check_frame(4, 100, "t5b");
        repeat (3) @(posedge clk);
        #1;

        // Reset while a column at index 7 is on the bus.
        start_frame(2, 10);
        ok = 1'b0;
        for (int n = 0; n < 8000; n++) begin
            @(posedge clk);
            #1;
            if (col_if.col_valid && col_if.col_idx == 5'd7) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("t6_reached_idx7", ok, 1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_tr", toggle_restart, 0);
        check_eq("t6_tn", toggle_next, 0);
        check_eq("t6_valid", col_if.col_valid, 0);
        check_eq("t6_data", col_if.col_data, 0);
        check_eq("t6_idx", col_if.col_idx, 0);
        check_eq("t6_last", col_if.col_last, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_done", frame_done, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1, 0, "t6");

        for (int r = 0; r < 3; r++) begin
            b = $urandom_range(0, 7);
            s = $urandom_range(0, 127);
            stall_mode = ($urandom_range(0, 1) == 1);
            run_frame(b, s, $sformatf("rnd%0d", r));
        end
        stall_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
